// File: rtl/iram_pkg.sv
// Shared definitions for the programmable instruction memory, the decoder and the bench.
package iram_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2
  } iram_state_t;

  // Encodes add r0,r0,r0 (R-type with all-zero fields)
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Opcode field position and values
  localparam int unsigned OPC_HI = 31;
  localparam int unsigned OPC_LO = 26;

  localparam logic [5:0] R_TYPE = 6'd0;
  localparam logic [5:0] ADDI   = 6'd1;
  localparam logic [5:0] MULI   = 6'd2;
  localparam logic [5:0] STORE  = 6'd3;
  localparam logic [5:0] LOAD   = 6'd4;
  localparam logic [5:0] JUMP   = 6'd5;
  localparam logic [5:0] BRANCH = 6'd6;

endpackage

// File: rtl/iram_bank.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
module iram_bank #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [XLEN-1:0]          wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [XLEN-1:0]          rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  // Read data only updates on an enabled read, so it holds between fetches
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/iram_prog.sv
// Programmable instruction memory: image streamed in over a valid/ready port, then
// served to fetch with 1-cycle latency, alignment/range faults and a stall until loaded.
module iram_prog
  import iram_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     DEPTH     = 256,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_req,
  input  logic [XLEN-1:0]        pc,
  output logic [XLEN-1:0]        instr,
  output logic                   instr_valid,
  output logic                   fetch_fault,
  input  logic                   ld_start,
  input  logic                   ld_valid,
  input  logic [XLEN-1:0]        ld_data,
  input  logic                   ld_last,
  output logic                   ld_ready,
  output logic                   ld_done,
  output logic [$clog2(DEPTH):0] ld_len
);

  localparam int unsigned AW = $clog2(DEPTH);

  iram_state_t     state, state_nxt;
  logic [AW-1:0]   ptr;
  logic [XLEN-3:0] widx;
  logic            accept;
  logic            last_word;
  logic            fetch_en;
  logic            fetch_bad;
  logic            sel_nop;
  logic [XLEN-1:0] rd_data;

  always_comb begin
    state_nxt = state;
    widx      = pc[XLEN-1:2];
    fetch_en  = (state == S_RUN) && fetch_req;
    fetch_bad = (pc[1:0] != 2'b00) || (widx >= (XLEN-2)'(ld_len));
    accept    = (state == S_LOAD) && ld_valid && ld_ready;
    last_word = accept && (ld_last || (ptr == AW'(DEPTH - 1)));
    case (state)
      S_EMPTY: if (ld_start)  state_nxt = S_LOAD;
      S_LOAD:  if (last_word) state_nxt = S_RUN;
      S_RUN:   if (ld_start)  state_nxt = S_LOAD;
      default:                state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_EMPTY;
      ptr         <= '0;
      ld_len      <= '0;
      ld_ready    <= 1'b0;
      ld_done     <= 1'b0;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
      sel_nop     <= 1'b1;
    end else begin
      state       <= state_nxt;
      ld_ready    <= (state_nxt == S_LOAD);
      ld_done     <= last_word;
      instr_valid <= fetch_en;
      fetch_fault <= fetch_en && fetch_bad;
      if ((state != S_LOAD) && (state_nxt == S_LOAD)) begin
        ptr    <= '0;
        ld_len <= '0;
      end else if (accept) begin
        ptr    <= ptr + AW'(1);
        ld_len <= ld_len + (AW+1)'(1);
      end
      if (fetch_en) begin
        sel_nop <= fetch_bad;
      end
    end
  end

  // instr is NOP after reset/fault, otherwise the registered RAM word (held while stalled)
  assign instr = sel_nop ? NOP_INSTR : rd_data;

  iram_bank #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_bank (
    .clk   (clk),
    .we    (accept),
    .waddr (ptr),
    .wdata (ld_data),
    .re    (fetch_en && !fetch_bad),
    .raddr (pc[AW+1:2]),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_iram_prog.sv
// Directed self-checking bench for iram_prog (DEPTH reduced to 16 to keep the full-depth load short).
module tb_iram_prog;
  import iram_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            fetch_req;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] instr;
  logic            instr_valid;
  logic            fetch_fault;
  logic            ld_start;
  logic            ld_valid;
  logic [XLEN-1:0] ld_data;
  logic            ld_last;
  logic            ld_ready;
  logic            ld_done;
  logic [LW-1:0]   ld_len;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] prog [8] = '{32'h04850001, 32'h04860004, 32'h00A61800, 32'h08630002,
                            32'h10630000, 32'h0C600000, 32'h14000000, 32'h18230005};
  logic [31:0] w0;

  iram_prog #(
    .XLEN      (XLEN),
    .DEPTH     (DEPTH),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .fetch_fault (fetch_fault),
    .ld_start    (ld_start),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .ld_ready    (ld_ready),
    .ld_done     (ld_done),
    .ld_len      (ld_len)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_instr,
                       input logic exp_fault, input string tag);
    fetch_req = 1'b1;
    pc        = addr;
    tick();
    check({tag, ".valid"}, 64'(instr_valid), 64'd1);
    check({tag, ".fault"}, 64'(fetch_fault), 64'(exp_fault));
    check({tag, ".instr"}, 64'(instr), 64'(exp_instr));
  endtask

  task automatic start_load();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic push(input logic [31:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; fetch_req = 1'b0; pc = '0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    #12;
    // Test 1: reset values and stall while empty
    check("rst.instr", 64'(instr), 64'h0);
    check("rst.valid", 64'(instr_valid), 64'd0);
    check("rst.fault", 64'(fetch_fault), 64'd0);
    check("rst.ready", 64'(ld_ready), 64'd0);
    check("rst.done", 64'(ld_done), 64'd0);
    check("rst.len", 64'(ld_len), 64'd0);
    rst_n = 1'b1;
    tick();
    fetch_req = 1'b1; pc = '0;
    tick();
    check("empty.valid", 64'(instr_valid), 64'd0);
    check("empty.instr", 64'(instr), 64'h0);
    fetch_req = 1'b0;

    // Test 2: load 8-word program, fetch back-to-back
    start_load();
    check("t2.ready", 64'(ld_ready), 64'd1);
    check("t2.len0", 64'(ld_len), 64'd0);
    for (int i = 0; i < 8; i++) begin
      ld_valid = 1'b1; ld_data = prog[i]; ld_last = (i == 7);
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    check("t2.done", 64'(ld_done), 64'd1);
    check("t2.ready_off", 64'(ld_ready), 64'd0);
    check("t2.len", 64'(ld_len), 64'd8);
    tick();
    check("t2.done_pulse", 64'(ld_done), 64'd0);
    for (int i = 0; i < 8; i++) begin
      fetch(32'(4 * i), prog[i], 1'b0, $sformatf("t2.f%0d", i));
    end
    w0 = prog[0];
    fetch(32'd0, prog[0], 1'b0, "t2.refetch0");
    check("t2.opcode", 64'(instr[OPC_HI:OPC_LO]), 64'(ADDI));

    // Test 3: faults and hold
    fetch(32'd6, 32'h0, 1'b1, "t3.misalign");
    fetch(32'd32, 32'h0, 1'b1, "t3.range");
    fetch(32'h1000_0000, 32'h0, 1'b1, "t3.highbits");
    fetch(32'd28, 32'h18230005, 1'b0, "t3.last");
    fetch_req = 1'b0;
    tick();
    check("t3.stall_valid", 64'(instr_valid), 64'd0);
    check("t3.stall_fault", 64'(fetch_fault), 64'd0);
    check("t3.hold", 64'(instr), 64'h18230005);

    // Test 4: gapped load, ignored ld_start mid-load, stray ld_valid afterwards
    start_load();
    push(32'hA000_0000, 1'b0);
    tick();
    push(32'hA000_0001, 1'b0);
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    check("t4.len_mid", 64'(ld_len), 64'd2);
    push(32'hA000_0002, 1'b0);
    tick();
    push(32'hA000_0003, 1'b1);
    check("t4.done", 64'(ld_done), 64'd1);
    check("t4.len", 64'(ld_len), 64'd4);
    check("t4.ready_off", 64'(ld_ready), 64'd0);
    push(32'hDEAD_BEEF, 1'b0);
    push(32'hDEAD_BEEF, 1'b1);
    check("t4.stray_len", 64'(ld_len), 64'd4);
    check("t4.stray_ready", 64'(ld_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      fetch(32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, $sformatf("t4.f%0d", i));
    end
    fetch(32'd16, 32'h0, 1'b1, "t4.range");

    // Test 5: full-depth load without ld_last; ld_start with concurrent fetch
    fetch_req = 1'b1; pc = 32'd4; ld_start = 1'b1;
    tick();
    ld_start = 1'b0; fetch_req = 1'b0;
    check("t5.concurrent_instr", 64'(instr), 64'hA000_0001);
    check("t5.concurrent_valid", 64'(instr_valid), 64'd1);
    for (int i = 0; i < DEPTH; i++) begin
      ld_valid = 1'b1; ld_data = 32'h5000_0000 + 32'(i);
      tick();
    end
    ld_valid = 1'b0;
    check("t5.done", 64'(ld_done), 64'd1);
    check("t5.len", 64'(ld_len), 64'(DEPTH));
    check("t5.ready_off", 64'(ld_ready), 64'd0);
    fetch(32'(4 * (DEPTH - 1)), 32'h5000_0000 + 32'(DEPTH - 1), 1'b0, "t5.lastword");
    fetch(32'd0, 32'h5000_0000, 1'b0, "t5.first");
    fetch(32'(4 * DEPTH), 32'h0, 1'b1, "t5.range");
    fetch_req = 1'b0;

    // Test 6: reset mid-load, then reload
    start_load();
    for (int i = 0; i < 3; i++) push(32'h7000_0000 + 32'(i), 1'b0);
    check("t6.len3", 64'(ld_len), 64'd3);
    rst_n = 1'b0;
    #1;
    check("t6.rst_len", 64'(ld_len), 64'd0);
    check("t6.rst_ready", 64'(ld_ready), 64'd0);
    check("t6.rst_valid", 64'(instr_valid), 64'd0);
    check("t6.rst_instr", 64'(instr), 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    fetch_req = 1'b1; pc = '0;
    tick();
    check("t6.stall_valid", 64'(instr_valid), 64'd0);
    fetch_req = 1'b0;
    start_load();
    push(32'h8000_0000, 1'b0);
    push(32'h8000_0001, 1'b1);
    check("t6.len", 64'(ld_len), 64'd2);
    fetch(32'd0, 32'h8000_0000, 1'b0, "t6.f0");
    fetch(32'd4, 32'h8000_0001, 1'b0, "t6.f1");
    fetch(32'd8, 32'h0, 1'b1, "t6.range");
    fetch_req = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
